// File: rtl/cycle_sequencer.sv
// -----------------------------------------------------------------------------
// cycle_sequencer
//
// Instruction-cycle controller for the Q2 datapath. Steps PC / IR /
// effective-address register / accumulator through FETCH, DECODE, optional
// INDIR and EXEC. It drives the register load/increment enables and runs the
// memory read/write handshake. A bounded wait counter traps a memory access
// that never sees mem_ready.
//
// Parameters
//   MEM_WAIT_MAX  max wait cycles per memory access (0 disables the timeout)
//   WAIT_W        wait counter width, MEM_WAIT_MAX < 2**WAIT_W
//
// Ports
//   clk        system clock, rising edge
//   nrst       synchronous reset, active-low
//   run        front-panel run level (used in IDLE and HALT only)
//   halt_req   front-panel halt request, sampled in DECODE
//   ir_op      opcode from IR (0 LOAD, 1 ADD, 2 STORE, 3 JUMP, 4 HALT, 5-7 NOP)
//   ir_ind     indirect-address bit from IR
//   mem_ready  memory access complete
//   mem_rd     memory read request (Moore)
//   mem_wr     memory write request (Moore)
//   mar_sel    address mux: 0 = PC, 1 = effective-address register (Moore)
//   ir_load    strobe: load IR from memory data
//   pc_inc     strobe: increment PC
//   pc_load    strobe: load PC from effective-address register
//   ea_load    strobe: load effective-address register from memory data
//   a_load     strobe: load accumulator from ALU
//   alu_add    ALU function qualifier for a_load: 1 = A + mem, 0 = pass mem
//   state      current state (IDLE 0 .. FAULT 6)
//   busy       state is FETCH, DECODE, INDIR or EXEC
//   fault      state is FAULT
// -----------------------------------------------------------------------------
module cycle_sequencer #(
    parameter int MEM_WAIT_MAX = 7,
    parameter int WAIT_W       = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       run,
    input  logic       halt_req,
    input  logic [2:0] ir_op,
    input  logic       ir_ind,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       mar_sel,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       ea_load,
    output logic       a_load,
    output logic       alu_add,
    output logic [2:0] state,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_INDIR  = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_JUMP  = 3'd3;
    localparam logic [2:0] OP_HALT  = 3'd4;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);
    localparam logic              TIMEOUT_EN = (MEM_WAIT_MAX != 0);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic exec_rd;      // EXEC reads memory (LOAD/ADD)
    logic exec_wr;      // EXEC writes memory (STORE)
    logic mem_state;    // a memory request is outstanding this cycle
    logic timeout;      // last permitted wait cycle passed without ready

    // Strobes before reset gating
    logic ir_load_c, pc_inc_c, pc_load_c, ea_load_c, a_load_c, alu_add_c;

    // ------------------------------------------------------------------
    // Moore memory-request outputs. IR is already loaded whenever EXEC is
    // active, so ir_op is stable there and acts as part of the state.
    // ------------------------------------------------------------------
    assign exec_rd   = (ir_op == OP_LOAD) || (ir_op == OP_ADD);
    assign exec_wr   = (ir_op == OP_STORE);

    assign mem_rd    = (state_q == S_FETCH) || (state_q == S_INDIR) ||
                       ((state_q == S_EXEC) && exec_rd);
    assign mem_wr    = (state_q == S_EXEC) && exec_wr;
    assign mar_sel   = (state_q == S_INDIR) ||
                       ((state_q == S_EXEC) && (exec_rd || exec_wr));
    assign mem_state = mem_rd || mem_wr;

    // Ready on the limit cycle wins: timeout only fires with mem_ready low.
    assign timeout   = TIMEOUT_EN && mem_state && !mem_ready &&
                       (wait_q == WAIT_LIMIT);

    // ------------------------------------------------------------------
    // Next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ir_load_c = 1'b0;
        pc_inc_c  = 1'b0;
        pc_load_c = 1'b0;
        ea_load_c = 1'b0;
        a_load_c  = 1'b0;
        alu_add_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end

            S_FETCH: begin
                if (mem_ready) begin
                    ir_load_c = 1'b1;
                    pc_inc_c  = 1'b1;
                    state_d   = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end

            S_DECODE: begin
                // Priority: front-panel halt, HALT opcode, indirect, then
                // direct dispatch.
                if (halt_req || (ir_op == OP_HALT)) begin
                    state_d = S_HALT;
                end else if (ir_ind && (ir_op <= OP_JUMP)) begin
                    state_d = S_INDIR;
                end else if (ir_op == OP_JUMP) begin
                    pc_load_c = 1'b1;
                    state_d   = S_FETCH;
                end else if (ir_op <= OP_STORE) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_INDIR: begin
                if (mem_ready) begin
                    ea_load_c = 1'b1;
                    state_d   = S_EXEC;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end

            S_EXEC: begin
                if (ir_op == OP_JUMP) begin
                    // Only reached through INDIR; no memory access.
                    pc_load_c = 1'b1;
                    state_d   = S_FETCH;
                end else if (exec_rd || exec_wr) begin
                    if (mem_ready) begin
                        a_load_c  = exec_rd;
                        alu_add_c = (ir_op == OP_ADD);
                        state_d   = S_FETCH;
                    end else if (timeout) begin
                        state_d = S_FAULT;
                    end
                end else begin
                    // Not reachable from DECODE; recover to FETCH.
                    state_d = S_FETCH;
                end
            end

            S_HALT: begin
                if (!run) state_d = S_IDLE;
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Wait counter: zero on entry to any state, counts cycles a memory
    // request sees no ready. Saturates so a disabled timeout never wraps.
    // ------------------------------------------------------------------
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_state && !mem_ready && (wait_q != '1)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // A reset cycle abandons any outstanding access without side effects,
    // so strobes are suppressed while nrst is low.
    assign ir_load = ir_load_c & nrst;
    assign pc_inc  = pc_inc_c  & nrst;
    assign pc_load = pc_load_c & nrst;
    assign ea_load = ea_load_c & nrst;
    assign a_load  = a_load_c  & nrst;
    assign alu_add = alu_add_c & nrst;

    assign state = state_q;
    assign busy  = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                   (state_q == S_INDIR) || (state_q == S_EXEC);
    assign fault = (state_q == S_FAULT);

endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Instruction-cycle controller for the Q2 datapath. It steps the discrete-flop registers (PC, IR, effective-address register, accumulator) through fetch, decode, optional indirect and execute. It drives their load/increment enables and runs the memory read/write handshake. It sits between the front-panel run/halt controls and the register/memory datapath, and contains a bounded wait counter that traps a memory cycle that never completes.

## Interface
- MEM_WAIT_MAX, 7: max cycles a memory access may wait for mem_ready; 0 disables the timeout
- WAIT_W, 4: wait counter width; must satisfy MEM_WAIT_MAX < 2^WAIT_W
- clk  in  1  system clock, all state changes on rising edge
- nrst  in  1  synchronous reset, active-low
- run  in  1  front-panel run level
- halt_req  in  1  front-panel halt request, sampled in DECODE
- ir_op  in  3  opcode from IR: 0 LOAD, 1 ADD, 2 STORE, 3 JUMP, 4 HALT, 5-7 NOP
- ir_ind  in  1  indirect-address bit from IR
- mem_ready  in  1  memory access complete, valid while mem_rd or mem_wr high
- mem_rd  out  1  memory read request, held until ready
- mem_wr  out  1  memory write request, held until ready
- mar_sel  out  1  address mux: 0 = PC, 1 = effective-address register
- ir_load  out  1  load IR from memory data
- pc_inc  out  1  increment PC
- pc_load  out  1  load PC from effective-address register
- ea_load  out  1  load effective-address register from memory data
- a_load  out  1  load accumulator from ALU
- alu_add  out  1  ALU function: 1 = A + mem, 0 = pass mem
- state  out  3  IDLE 0, FETCH 1, DECODE 2, INDIR 3, EXEC 4, HALT 5, FAULT 6
- busy  out  1  state is FETCH, DECODE, INDIR or EXEC
- fault  out  1  state is FAULT

## Operation
- mem_rd, mem_wr and mar_sel are Moore outputs decoded from the registered state. Strobes (ir_load, pc_inc, pc_load, ea_load, a_load, alu_add) are single-cycle, combinational from state, ir_op and mem_ready.
- IDLE: all outputs 0. run=1 -> FETCH.
- FETCH: mem_rd=1, mar_sel=0. On mem_ready=1: ir_load=1 and pc_inc=1 in that cycle, -> DECODE.
- DECODE (exactly 1 cycle, no memory access):
  - halt_req=1 -> HALT; the instruction is not executed.
  - else ir_op=4 -> HALT.
  - else ir_ind=1 and ir_op in 0..3 -> INDIR.
  - else ir_op=3 -> pc_load=1, -> FETCH.
  - else ir_op in 0..2 -> EXEC.
  - else (NOP) -> FETCH.
- INDIR: mem_rd=1, mar_sel=1. On mem_ready: ea_load=1, -> EXEC.
- EXEC:
  - LOAD/ADD: mem_rd=1, mar_sel=1. On ready: a_load=1, with alu_add=1 for ADD; -> FETCH.
  - STORE: mem_wr=1, mar_sel=1. On ready: -> FETCH.
  - JUMP (only reached via INDIR): pc_load=1 for 1 cycle, no memory access; -> FETCH.
- HALT: all outputs 0. run=0 -> IDLE. A later run=1 restarts from the current PC.
- FAULT: all outputs 0. Exits only on reset.
- Wait counter:
  - Clears on entry to any state.
  - Increments each cycle a memory state sees mem_ready=0.
  - If the count equals MEM_WAIT_MAX while mem_ready=0 and MEM_WAIT_MAX≠0 -> FAULT. mem_rd/mem_wr drop the next cycle.
  - mem_ready=1 on the limit cycle completes the access normally; ready wins.
- run is ignored outside IDLE and HALT. Dropping run mid-instruction does not abort the instruction.

## Timing
- Reset: nrst=0 at a rising clk edge -> state=IDLE, wait counter 0, every output 0 from the next cycle. This applies mid-access too; an outstanding mem_rd/mem_wr is dropped with no strobe.
- Minimum instruction cycles, zero-wait memory:
  - NOP/HALT: 2 (FETCH, DECODE).
  - Direct JUMP: 2; pc_load in the DECODE cycle.
  - LOAD/ADD/STORE: 3.
  - Indirect: +1; indirect JUMP = 4.
- Each memory wait cycle adds 1.
- Request is asserted in the first cycle of the state. Completion is the cycle mem_ready=1 is sampled. The next state begins the following cycle, so there is no idle cycle between back-to-back accesses.
- ir_op and ir_ind are used only from DECODE onward, when IR is already loaded.

## Test plan
- Reset, run=1, ready tied high, memory word ir_op=0 ir_ind=0 -> state 0,1,2,4,1; ir_load+pc_inc at cycle 1, a_load=1 alu_add=0 at cycle 3.
- ADD with ready delayed 3 cycles in EXEC -> mem_rd held 4 cycles, single a_load with alu_add=1, no fault (MEM_WAIT_MAX=7).
- Indirect JUMP, zero wait -> FETCH, DECODE, INDIR (ea_load), EXEC (pc_load), FETCH; mem_rd never high in EXEC.
- ready stuck low in FETCH, MEM_WAIT_MAX=7 -> state=6 after 8 cycles in FETCH, mem_rd=0 thereafter, remains FAULT until nrst=0.
- halt_req=1 during the DECODE of a STORE -> HALT, mem_wr never asserted. run=0 -> IDLE, run=1 -> FETCH with mar_sel=0.
- nrst=0 during an INDIR access awaiting ready -> next cycle state=0 and all strobes 0; ready arriving afterward produces no ea_load.
